// File: rtl/axi_burst_responder.sv
// AXI4-style burst responder: independent write (AW/W/B) and read (AR/R) state machines
// sharing one word-organised memory; FIXED/INCR/WRAP beat addresses are generated internally.
//
// state   | meaning
// W_IDLE  | awready high, waiting for a write address
// W_DATA  | wready high, committing beats until the down-counter reaches zero
// W_RESP  | bvalid high, sticky bresp held until bready
// R_IDLE  | arready high, waiting for a read address
// R_DATA  | rvalid high, next beat loaded on each handshake
module axi_burst_responder #(
  parameter int size  = 4,
  parameter int depth = 64,
  parameter int aw    = 32
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              awvalid,
  output logic              awready,
  input  logic [aw-1:0]     awadd,
  input  logic [7:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              wvalid,
  output logic              wready,
  input  logic [size*8-1:0] wdata,
  input  logic [size-1:0]   wstrb,
  input  logic              wlast,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [aw-1:0]     aradd,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  output logic              rvalid,
  input  logic              rready,
  output logic [size*8-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast
);

  localparam int dw = size * 8;
  localparam int lg = $clog2(size);
  localparam int iw = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [aw-1:0] limit = aw'(depth * size);
  localparam logic [1:0] okay   = 2'b00;
  localparam logic [1:0] slverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic logic attr_bad(input logic [2:0] sz, input logic [1:0] bt, input logic [7:0] ln);
    logic wrap_len_ok;
    wrap_len_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
    return (int'(sz) > lg) || (bt == 2'b11) || ((bt == 2'b10) && !wrap_len_ok);
  endfunction

  // WRAP window size is a power of two for every legal len, so the window is a mask.
  function automatic logic [aw-1:0] next_addr(input logic [aw-1:0] a, input logic [2:0] sz,
                                              input logic [7:0] ln, input logic [1:0] bt);
    logic [aw-1:0] step, mask, lower, nxt;
    step  = aw'(1) << sz;
    mask  = (aw'(ln) << sz) | (step - aw'(1));
    lower = a & ~mask;
    nxt   = a + step;
    case (bt)
      2'b00:   return a;
      2'b10:   return (nxt > lower + mask) ? lower : nxt;
      default: return nxt;
    endcase
  endfunction

  function automatic logic [size-1:0] lane_mask(input logic [2:0] sz);
    logic [size-1:0] m;
    m = '0;
    for (int i = 0; i < size; i++) m[i] = ((i >> sz) == 0);
    return m;
  endfunction

  logic [dw-1:0] mem [depth];

  w_state_t      w_state;
  logic [aw-1:0] w_addr;
  logic [7:0]    w_cnt, w_len;
  logic [2:0]    w_size;
  logic [1:0]    w_burst;
  logic          w_attr_err, w_err;

  logic          w_fire, w_beat_err, w_last_beat, w_last_err, mem_we;
  logic [iw-1:0] w_idx;
  logic [size-1:0] w_strb_eff;

  always_comb begin
    w_fire      = (w_state == W_DATA) && wvalid && wready;
    w_beat_err  = w_attr_err || (w_addr >= limit);
    w_last_beat = (w_cnt == 8'd0);
    w_last_err  = (wlast != w_last_beat);
    w_idx       = iw'(w_addr >> lg);
    w_strb_eff  = wstrb & lane_mask(w_size);
    mem_we      = w_fire && !w_beat_err && !reset;
  end

  always_ff @(posedge aclk) begin
    if (mem_we)
      for (int i = 0; i < size; i++)
        if (w_strb_eff[i]) mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      w_state    <= W_IDLE;
      awready    <= 1'b0;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= okay;
      w_addr     <= '0;
      w_cnt      <= '0;
      w_len      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_attr_err <= 1'b0;
      w_err      <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_addr     <= awadd;
            w_cnt      <= awlen;
            w_len      <= awlen;
            w_size     <= awsize;
            w_burst    <= awburst;
            w_attr_err <= attr_bad(awsize, awburst, awlen);
            w_err      <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b1;
            w_state    <= W_DATA;
          end else begin
            awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            if (w_beat_err || w_last_err) w_err <= 1'b1;
            w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
            w_cnt  <= w_cnt - 8'd1;
            if (w_last_beat) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bresp   <= (w_err || w_beat_err || w_last_err) ? slverr : okay;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  r_state_t      r_state;
  logic [aw-1:0] r_addr;
  logic [7:0]    r_cnt, r_len;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic          r_attr_err;

  logic          ar_fire, ld_attr, ld_err;
  logic [aw-1:0] ld_addr;
  logic [7:0]    ld_cnt;
  logic [dw-1:0] ld_word;

  // Memory is read combinationally here, so a same-edge write commit is not yet visible.
  always_comb begin
    ar_fire = (r_state == R_IDLE) && arvalid && arready;
    ld_addr = ar_fire ? aradd : next_addr(r_addr, r_size, r_len, r_burst);
    ld_attr = ar_fire ? attr_bad(arsize, arburst, arlen) : r_attr_err;
    ld_cnt  = ar_fire ? arlen : r_cnt - 8'd1;
    ld_err  = ld_attr || (ld_addr >= limit);
    ld_word = mem[iw'(ld_addr >> lg)];
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state    <= R_IDLE;
      arready    <= 1'b0;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= okay;
      rlast      <= 1'b0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_attr_err <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            r_len      <= arlen;
            r_size     <= arsize;
            r_burst    <= arburst;
            r_attr_err <= ld_attr;
            r_addr     <= ld_addr;
            r_cnt      <= ld_cnt;
            rvalid     <= 1'b1;
            rdata      <= ld_err ? '0 : ld_word;
            rresp      <= ld_err ? slverr : okay;
            rlast      <= (ld_cnt == 8'd0);
            arready    <= 1'b0;
            r_state    <= R_DATA;
          end else begin
            arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= ld_addr;
              r_cnt  <= ld_cnt;
              rdata  <= ld_err ? '0 : ld_word;
              rresp  <= ld_err ? slverr : okay;
              rlast  <= (ld_cnt == 8'd0);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_burst_responder.sv
// Scoreboard bench for axi_burst_responder: drivers push expected B/R responses computed from a
// byte-level memory model; a negedge monitor compares every presented response against the queues.
module tb_axi_burst_responder;

  localparam int SIZE  = 4;
  localparam int DEPTH = 64;
  localparam int AW    = 32;
  localparam int LIMIT = DEPTH * SIZE;

  logic          aclk, reset;
  logic          awvalid, awready;
  logic [AW-1:0] awadd;
  logic [7:0]    awlen;
  logic [2:0]    awsize;
  logic [1:0]    awburst;
  logic          wvalid, wready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wlast;
  logic          bvalid, bready;
  logic [1:0]    bresp;
  logic          arvalid, arready;
  logic [AW-1:0] aradd;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          rvalid, rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rlast;

  axi_burst_responder #(.size(SIZE), .depth(DEPTH), .aw(AW)) dut (
    .aclk(aclk), .reset(reset),
    .awvalid(awvalid), .awready(awready), .awadd(awadd), .awlen(awlen), .awsize(awsize),
    .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .aradd(aradd), .arlen(arlen), .arsize(arsize),
    .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mdl [DEPTH];
  logic [1:0]  bq [$];
  rbeat_t      rq [$];
  longint      ba [256];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic        wl [256];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    errors++;
    $display("FAIL timeout %s at %0t", name, $time);
  endtask

  function automatic bit m_attr_err(input int sz, input int bt, input int ln);
    return (sz > 2) || (bt == 3) || ((bt == 2) && !(ln inside {1, 3, 7, 15}));
  endfunction

  // Beat addresses straight from the burst rules: start, step by 2^size, wrap back to the window base.
  function automatic void beat_addrs(input longint start, input int sz, input int ln, input int bt);
    longint bytes, total, lower, a;
    bytes = longint'(1) << sz;
    total = bytes * (ln + 1);
    lower = (start / total) * total;
    a = start;
    for (int k = 0; k <= ln; k++) begin
      ba[k] = a;
      if (bt != 0) a = a + bytes;
      if (bt == 2 && a >= lower + total) a = lower;
    end
  endfunction

  task automatic set_beats(input int ln);
    for (int k = 0; k <= ln; k++) begin
      wd[k] = $urandom;
      ws[k] = 4'hF;
      wl[k] = (k == ln);
    end
  endtask

  task automatic do_write(input longint start, input int sz, input int ln, input int bt);
    bit err;
    int n, d;
    err = m_attr_err(sz, bt, ln);
    beat_addrs(start, sz, ln, bt);
    for (int k = 0; k <= ln; k++) begin
      if (wl[k] != (k == ln)) err = 1;
      if (m_attr_err(sz, bt, ln) || ba[k] >= LIMIT) err = 1;
      else
        for (int i = 0; i < (1 << sz) && i < SIZE; i++)
          if (ws[k][i]) mdl[6'(ba[k] / SIZE)][i*8 +: 8] = wd[k][i*8 +: 8];
    end
    bq.push_back(err ? 2'b10 : 2'b00);
    @(posedge aclk); #1;
    awvalid = 1; awadd = 32'(start); awlen = 8'(ln); awsize = 3'(sz); awburst = 2'(bt);
    n = 0;
    @(negedge aclk);
    while (!awready && n < 100) begin @(negedge aclk); n++; end
    if (!awready) tmo("aw_handshake");
    @(posedge aclk); #1;
    awvalid = 0;
    for (int k = 0; k <= ln; k++) begin
      d = ($urandom_range(3) == 0) ? 1 : 0;
      repeat (d) begin @(posedge aclk); #1; end
      wvalid = 1; wdata = wd[k]; wstrb = ws[k]; wlast = wl[k];
      n = 0;
      @(negedge aclk);
      while (!wready && n < 100) begin @(negedge aclk); n++; end
      if (!wready) tmo("w_handshake");
      @(posedge aclk); #1;
      wvalid = 0; wlast = 0;
    end
    d = $urandom_range(2);
    repeat (d) begin @(posedge aclk); #1; end
    bready = 1;
    n = 0;
    while (bq.size() != 0 && n < 100) begin @(posedge aclk); n++; end
    #1;
    if (bq.size() != 0) begin tmo("b_response"); bq.delete(); end
    bready = 0;
  endtask

  task automatic do_read(input longint start, input int sz, input int ln, input int bt, input bit stall);
    bit err;
    int n, cyc;
    beat_addrs(start, sz, ln, bt);
    for (int k = 0; k <= ln; k++) begin
      err = m_attr_err(sz, bt, ln) || (ba[k] >= LIMIT);
      rq.push_back('{err ? 32'h0 : mdl[6'(ba[k] / SIZE)], err ? 2'b10 : 2'b00, k == ln});
    end
    @(posedge aclk); #1;
    arvalid = 1; aradd = 32'(start); arlen = 8'(ln); arsize = 3'(sz); arburst = 2'(bt);
    n = 0;
    @(negedge aclk);
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    if (!arready) tmo("ar_handshake");
    @(posedge aclk); #1;
    arvalid = 0;
    cyc = 0;
    while (rq.size() != 0 && cyc < 600) begin
      rready = stall ? !(cyc >= 2 && cyc <= 4) : ($urandom_range(3) != 0);
      @(posedge aclk); #1;
      cyc++;
    end
    if (rq.size() != 0) begin tmo("r_beats"); rq.delete(); end
    rready = 0;
  endtask

  always @(negedge aclk) begin
    if (!reset) begin
      if (bvalid) begin
        if (bq.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected: bresp=%0h with nothing expected at %0t", bresp, $time);
        end else begin
          check("bresp", 64'(bresp), 64'(bq[0]));
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL r_unexpected: rdata=%0h with nothing expected at %0t", rdata, $time);
        end else begin
          check("rdata", 64'(rdata), 64'(rq[0].data));
          check("rresp", 64'(rresp), 64'(rq[0].resp));
          check("rlast", 64'(rlast), 64'(rq[0].last));
          if (rready) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hs;
    reset = 1;
    awvalid = 0; awadd = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
    arvalid = 0; aradd = 0; arlen = 0; arsize = 0; arburst = 0; rready = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_awready", 64'(awready), 0);
    check("rst_wready", 64'(wready), 0);
    check("rst_bvalid", 64'(bvalid), 0);
    check("rst_bresp", 64'(bresp), 0);
    check("rst_arready", 64'(arready), 0);
    check("rst_rvalid", 64'(rvalid), 0);
    check("rst_rdata", 64'(rdata), 0);
    check("rst_rresp", 64'(rresp), 0);
    check("rst_rlast", 64'(rlast), 0);
    @(posedge aclk); #1;
    reset = 0;
    @(posedge aclk);
    @(negedge aclk);
    check("idle_awready", 64'(awready), 1);
    check("idle_arready", 64'(arready), 1);

    set_beats(63);
    do_write(0, 2, 63, 1);

    for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0 + k; ws[k] = 4'hF; wl[k] = (k == 3); end
    do_write(32'h10, 2, 3, 1);
    do_read(32'h10, 2, 3, 1, 0);

    set_beats(3);
    do_write(32'h34, 2, 3, 2);
    do_read(32'h34, 2, 3, 2, 0);
    do_read(32'h30, 2, 3, 1, 0);

    for (int k = 0; k < 3; k++) begin wd[k] = k + 1; ws[k] = 4'hF; wl[k] = (k == 2); end
    do_write(32'h20, 2, 2, 0);
    do_read(32'h20, 2, 0, 1, 0);
    wd[0] = 32'h12345678; ws[0] = 4'hF; wl[0] = 1;
    do_write(32'h24, 2, 0, 1);
    wd[0] = 32'hFFFFFFFF; ws[0] = 4'b0011; wl[0] = 1;
    do_write(32'h24, 2, 0, 1);
    do_read(32'h24, 2, 0, 1, 0);

    set_beats(1);
    do_write(32'hFC, 2, 1, 1);
    do_read(32'hF8, 2, 2, 1, 0);
    do_read(32'h40, 2, 2, 3, 0);
    set_beats(2);
    do_write(32'h80, 2, 2, 2);
    do_read(32'h80, 2, 2, 1, 0);

    set_beats(3);
    wl[1] = 1; wl[3] = 0;
    do_write(32'h50, 2, 3, 1);
    do_read(32'h50, 2, 7, 1, 1);

    set_beats(3);
    fork
      do_write(32'h60, 2, 3, 1);
      do_read(32'hA0, 2, 3, 1, 0);
    join
    do_read(32'h60, 2, 3, 1, 0);

    // Reset in the middle of a read burst abandons it; memory survives.
    beat_addrs(0, 2, 7, 1);
    for (int k = 0; k <= 7; k++) rq.push_back('{mdl[6'(ba[k] / SIZE)], 2'b00, k == 7});
    @(posedge aclk); #1;
    arvalid = 1; aradd = 0; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1;
    n = 0;
    @(negedge aclk);
    while (!arready && n < 100) begin @(negedge aclk); n++; end
    if (!arready) tmo("ar_handshake_rst");
    @(posedge aclk); #1;
    arvalid = 0; rready = 1;
    hs = 0; n = 0;
    while (hs < 2 && n < 50) begin
      @(negedge aclk);
      if (rvalid && rready) hs++;
      n++;
    end
    if (hs < 2) tmo("r_beats_before_reset");
    @(posedge aclk); #1;
    reset = 1; rready = 0;
    @(posedge aclk); #1;
    rq.delete();
    reset = 0;
    @(negedge aclk);
    check("rvalid_after_reset", 64'(rvalid), 0);
    check("rlast_after_reset", 64'(rlast), 0);
    check("arready_in_reset_release", 64'(arready), 0);
    @(posedge aclk);
    @(negedge aclk);
    check("arready_after_reset", 64'(arready), 1);
    do_read(32'h40, 2, 3, 1, 0);

    for (int t = 0; t < 40; t++) begin
      int sz, bt, ln;
      longint st;
      sz = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 2;
      bt = $urandom_range(3);
      if (bt == 2) ln = ($urandom_range(5) == 0) ? 2 : (1 << $urandom_range(4, 1)) - 1;
      else ln = $urandom_range(15);
      st = longint'($urandom_range(32'h11F)) & ~((longint'(1) << sz) - 1);
      if ($urandom_range(1) == 1) begin
        set_beats(ln);
        for (int k = 0; k <= ln; k++) ws[k] = 4'($urandom);
        if ($urandom_range(9) == 0) wl[$urandom_range(ln)] ^= 1'b1;
        do_write(st, sz, ln, bt);
      end else begin
        do_read(st, sz, ln, bt, 0);
      end
    end

    repeat (3) @(posedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
